// File: rtl/mem_ctrl_pkg.sv
// mem_ctrl_pkg: shared states, length codes and helpers for the RAM port sequencer.
// Used by mem_ctrl through import mem_ctrl_pkg::*.
package mem_ctrl_pkg;

  localparam logic Enable  = 1'b1;
  localparam logic Disable = 1'b0;

  localparam logic [1:0] LEN_B = 2'b00;
  localparam logic [1:0] LEN_H = 2'b01;
  localparam logic [1:0] LEN_W = 2'b10;

  localparam logic [31:0] ZeroWord = 32'h0000_0000;

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_IF_RD,
    ST_MEM_RD,
    ST_MEM_WR
  } state_t;

  // Code 11 has no meaning of its own and is run as a word.
  function automatic logic [2:0] beats(input logic [1:0] len);
    logic [2:0] n;
    unique case (len)
      LEN_B:   n = 3'd1;
      LEN_H:   n = 3'd2;
      default: n = 3'd4;
    endcase
    return n;
  endfunction

  // Bytes enter the assembly register at the top, so a short read
  // ends up in the high bytes and is shifted down, zero-filled.
  function automatic logic [31:0] align(
    input logic [31:0] sr,
    input logic [2:0]  n
  );
    logic [31:0] d;
    unique case (n)
      3'd1:    d = {24'h0, sr[31:24]};
      3'd2:    d = {16'h0, sr[31:16]};
      default: d = sr;
    endcase
    return d;
  endfunction

endpackage

// File: rtl/mem_ctrl.sv
// mem_ctrl: sequences the byte-wide RAM port shared by IF and MEM (MEM wins).
// Ports: clk/rst, IF fetch req/cancel/data/done, MEM load/store with stall, RAM byte port.
module mem_ctrl
  import mem_ctrl_pkg::*;
#(
  parameter int ADDR_W = 17,
  parameter int XLEN   = 32
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              if_req,
  input  logic [XLEN-1:0]   if_addr,
  input  logic              if_cancel,
  output logic [XLEN-1:0]   if_data,
  output logic              if_done,
  input  logic              mem_req,
  input  logic              mem_we,
  input  logic [1:0]        mem_len,
  input  logic [XLEN-1:0]   mem_addr,
  input  logic [XLEN-1:0]   mem_wdata,
  output logic [XLEN-1:0]   mem_rdata,
  output logic              mem_done,
  output logic              mem_stall_req,
  output logic [ADDR_W-1:0] ram_addr,
  output logic              ram_wr,
  output logic [7:0]        ram_dout,
  input  logic [7:0]        ram_din
);

  state_t            r_state;
  logic [2:0]        r_cnt;
  logic [2:0]        r_beats;
  logic [XLEN-1:0]   r_base;
  logic [XLEN-1:0]   r_wdata;
  logic [23:0]       r_buf;
  logic              r_if_done;
  logic              r_mem_done;
  logic [XLEN-1:0]   r_if_data;
  logic [XLEN-1:0]   r_mem_rdata;

  logic [31:0]       w_sr;
  logic              w_last;
  logic              w_drive;
  logic              w_wr;
  logic [ADDR_W-1:0] w_addr;

  assign w_sr   = {ram_din, r_buf};
  assign w_last = (r_cnt == r_beats);
  assign w_addr = ADDR_W'(r_base + XLEN'(r_cnt));

  always_comb begin
    w_drive = Disable;
    w_wr    = Disable;
    unique case (r_state)
      ST_IF_RD,
      ST_MEM_RD: w_drive = (r_cnt < r_beats);
      ST_MEM_WR: begin
        w_drive = Enable;
        w_wr    = Enable;
      end
      default: ;
    endcase
  end

  // Gated by rst so a store cut short by reset never writes.
  assign ram_addr = (w_drive && !rst) ? w_addr : '0;
  assign ram_wr   = w_wr & ~rst;
  assign ram_dout = (w_wr && !rst) ?
                    r_wdata[{r_cnt[1:0], 3'b000} +: 8] : 8'h00;

  assign if_data       = r_if_data;
  assign if_done       = r_if_done;
  assign mem_rdata     = r_mem_rdata;
  assign mem_done      = r_mem_done;
  assign mem_stall_req = mem_req & ~r_mem_done;

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state     <= ST_IDLE;
      r_cnt       <= 3'd0;
      r_beats     <= 3'd0;
      r_base      <= '0;
      r_wdata     <= '0;
      r_buf       <= 24'h0;
      r_if_done   <= Disable;
      r_mem_done  <= Disable;
      r_if_data   <= XLEN'(ZeroWord);
      r_mem_rdata <= XLEN'(ZeroWord);
    end else begin
      r_if_done  <= Disable;
      r_mem_done <= Disable;
      unique case (r_state)
        ST_IDLE: begin
          // A done pulse means the requester has not dropped req yet.
          if (!r_if_done && !r_mem_done) begin
            if (mem_req) begin
              r_state <= mem_we ? ST_MEM_WR : ST_MEM_RD;
              r_base  <= mem_addr;
              r_beats <= beats(mem_len);
              r_wdata <= mem_wdata;
              r_cnt   <= 3'd0;
              r_buf   <= 24'h0;
            end else if (if_req && !if_cancel) begin
              r_state <= ST_IF_RD;
              r_base  <= if_addr;
              r_beats <= 3'd4;
              r_cnt   <= 3'd0;
              r_buf   <= 24'h0;
            end
          end
        end
        ST_IF_RD: begin
          if (if_cancel) begin
            r_state <= ST_IDLE;
          end else begin
            r_cnt <= r_cnt + 3'd1;
            if (r_cnt != 3'd0) r_buf <= w_sr[31:8];
            if (w_last) begin
              r_state   <= ST_IDLE;
              r_if_done <= Enable;
              r_if_data <= XLEN'(align(w_sr, r_beats));
            end
          end
        end
        ST_MEM_RD: begin
          r_cnt <= r_cnt + 3'd1;
          if (r_cnt != 3'd0) r_buf <= w_sr[31:8];
          if (w_last) begin
            r_state     <= ST_IDLE;
            r_mem_done  <= Enable;
            r_mem_rdata <= XLEN'(align(w_sr, r_beats));
          end
        end
        ST_MEM_WR: begin
          r_cnt <= r_cnt + 3'd1;
          if (r_cnt == r_beats - 3'd1) begin
            r_state    <= ST_IDLE;
            r_mem_done <= Enable;
          end
        end
        default: r_state <= ST_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_mem_ctrl.sv
// tb_mem_ctrl: directed and random checks of mem_ctrl against a byte-array model.
// The RAM below is the environment; expectations come from the mdl array.
module tb_mem_ctrl;

  localparam int AW  = 17;
  localparam int RSZ = 1 << AW;

  logic          clk = 1'b0;
  logic          rst;
  logic          if_req;
  logic [31:0]   if_addr;
  logic          if_cancel;
  logic [31:0]   if_data;
  logic          if_done;
  logic          mem_req;
  logic          mem_we;
  logic [1:0]    mem_len;
  logic [31:0]   mem_addr;
  logic [31:0]   mem_wdata;
  logic [31:0]   mem_rdata;
  logic          mem_done;
  logic          mem_stall_req;
  logic [AW-1:0] ram_addr;
  logic          ram_wr;
  logic [7:0]    ram_dout;
  logic [7:0]    ram_din;

  logic [7:0] ram [0:RSZ-1];
  logic [7:0] mdl [0:RSZ-1];
  bit         ram_ready = 1'b0;

  int n_assert = 0;
  int n_fail   = 0;

  mem_ctrl #(.ADDR_W(AW), .XLEN(32)) dut (
    .clk           (clk),
    .rst           (rst),
    .if_req        (if_req),
    .if_addr       (if_addr),
    .if_cancel     (if_cancel),
    .if_data       (if_data),
    .if_done       (if_done),
    .mem_req       (mem_req),
    .mem_we        (mem_we),
    .mem_len       (mem_len),
    .mem_addr      (mem_addr),
    .mem_wdata     (mem_wdata),
    .mem_rdata     (mem_rdata),
    .mem_done      (mem_done),
    .mem_stall_req (mem_stall_req),
    .ram_addr      (ram_addr),
    .ram_wr        (ram_wr),
    .ram_dout      (ram_dout),
    .ram_din       (ram_din)
  );

  always #5 clk = ~clk;

  function automatic logic [7:0] init_byte(input int a);
    logic [7:0] b;
    case (a)
      'h100:   b = 8'h13;
      'h101:   b = 8'h05;
      'h102:   b = 8'hA0;
      'h103:   b = 8'h00;
      'h204:   b = 8'h80;
      default: b = 8'((a * 37) ^ (a >> 5));
    endcase
    return b;
  endfunction

  // Synchronous RAM: read data for the address of cycle t shows in t+1.
  always @(posedge clk) begin
    if (!ram_ready) begin
      for (int i = 0; i < RSZ; i++) ram[i] = init_byte(i);
      ram_ready = 1'b1;
    end
    ram_din <= ram[ram_addr];
    if (ram_wr) ram[ram_addr] = ram_dout;
  end

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

  task automatic chk(input string tag, input logic [31:0] obs,
                     input logic [31:0] exp);
    n_assert++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s observed=0x%08h expected=0x%08h", tag, obs, exp);
    end
  endtask

  function automatic logic [AW-1:0] wa(input logic [31:0] a, input int k);
    return AW'(a + 32'(k));
  endfunction

  function automatic logic [31:0] mread(input logic [31:0] a, input int n);
    logic [31:0] d = '0;
    for (int k = 0; k < n; k++) d[8*k +: 8] = mdl[wa(a, k)];
    return d;
  endfunction

  // One whole transaction; starts and ends just after a posedge.
  task automatic op(input bit isf, input bit we, input logic [1:0] len,
                    input logic [31:0] a, input logic [31:0] wd,
                    output logic [31:0] rd);
    int n;
    int di;
    int wrs;
    bit st;
    logic [AW-1:0] alog[$];
    logic          wlog[$];
    logic [7:0]    dlog[$];
    st = !isf && we;
    n  = (isf || len == 2'b11) ? 4 : (1 << len);
    rd = '0;
    di = -1;
    if (isf) begin
      if_req  = 1'b1;
      if_addr = a;
    end else begin
      mem_req   = 1'b1;
      mem_we    = we;
      mem_len   = len;
      mem_addr  = a;
      mem_wdata = wd;
    end
    for (int c = 0; c < 40 && di < 0; c++) begin
      @(negedge clk);
      alog.push_back(ram_addr);
      wlog.push_back(ram_wr);
      dlog.push_back(ram_dout);
      if (!isf && c == 1) chk("stall_busy", 32'(mem_stall_req), 1);
      if (isf ? if_done : mem_done) begin
        di = c;
        rd = isf ? if_data : mem_rdata;
        if (!isf) chk("stall_at_done", 32'(mem_stall_req), 0);
      end
    end
    @(posedge clk); #1;
    if_req  = 1'b0;
    mem_req = 1'b0;
    chk("done_seen", 32'(di >= 0), 1);
    if (di >= 0) begin
      chk("latency", di, st ? n + 1 : n + 2);
      for (int k = 0; k < n; k++) begin
        if (1 + k < alog.size()) begin
          chk("ram_addr", 32'(alog[1+k]), 32'(wa(a, k)));
          chk("ram_wr", 32'(wlog[1+k]), 32'(st));
          if (st) chk("ram_dout", 32'(dlog[1+k]), 32'(wd[8*k +: 8]));
        end
      end
      if (st) begin
        for (int k = 0; k < n; k++) mdl[wa(a, k)] = wd[8*k +: 8];
        for (int k = 0; k < n; k++)
          chk("ram_byte", 32'(ram[wa(a, k)]), 32'(mdl[wa(a, k)]));
      end else begin
        chk(isf ? "if_data" : "mem_rdata", rd, mread(a, n));
      end
      if (!st) begin
        wrs = 0;
        foreach (wlog[i]) wrs += int'(wlog[i]);
        chk("read_no_wr", wrs, 0);
      end
    end
  endtask

  logic [31:0] rd;
  logic [31:0] ra;
  int          md;
  int          fd;
  bit          seen;

  initial begin
    for (int i = 0; i < RSZ; i++) mdl[i] = init_byte(i);
    rst = 1'b1;
    if_req = 1'b0;
    if_addr = '0;
    if_cancel = 1'b0;
    mem_req = 1'b0;
    mem_we = 1'b0;
    mem_len = 2'b00;
    mem_addr = '0;
    mem_wdata = '0;
    repeat (3) @(posedge clk);
    @(negedge clk);
    chk("rst_if_done", 32'(if_done), 0);
    chk("rst_mem_done", 32'(mem_done), 0);
    chk("rst_if_data", if_data, 0);
    chk("rst_mem_rdata", mem_rdata, 0);
    chk("rst_ram_addr", 32'(ram_addr), 0);
    chk("rst_ram_wr", 32'(ram_wr), 0);
    chk("rst_ram_dout", 32'(ram_dout), 0);
    @(posedge clk); #1;
    rst = 1'b0;

    // Fetch only
    op(1'b1, 1'b0, 2'b10, 32'h100, '0, rd);
    chk("t1_insn", rd, 32'h00A00513);

    // Store word
    op(1'b0, 1'b1, 2'b10, 32'h200, 32'hDEADBEEF, rd);
    chk("t2_bytes", {ram[17'h203], ram[17'h202], ram[17'h201], ram[17'h200]},
        32'hDEADBEEF);

    // IF and MEM together: MEM byte load first, IF after mem_done drops
    if_req = 1'b1;
    if_addr = 32'h100;
    mem_req = 1'b1;
    mem_we = 1'b0;
    mem_len = 2'b00;
    mem_addr = 32'h204;
    md = -1;
    fd = -1;
    for (int c = 0; c < 30 && fd < 0; c++) begin
      @(negedge clk);
      if (c == 1) chk("t3_stall_busy", 32'(mem_stall_req), 1);
      if (mem_done && md < 0) begin
        md = c;
        chk("t3_mem_rdata", mem_rdata, 32'h00000080);
        chk("t3_stall_done", 32'(mem_stall_req), 0);
        chk("t3_if_not_yet", 32'(if_done), 0);
      end
      if (if_done) begin
        fd = c;
        chk("t3_if_data", if_data, mread(32'h100, 4));
      end
      @(posedge clk); #1;
      if (md >= 0) mem_req = 1'b0;
      if (fd >= 0) if_req = 1'b0;
    end
    if_req = 1'b0;
    mem_req = 1'b0;
    chk("t3_mem_lat", md, 3);
    chk("t3_if_after", fd, md + 7);

    // Cancel at busy cycle 2 of a fetch
    seen = 1'b0;
    for (int c = 0; c < 12; c++) begin
      if (c == 0) begin
        if_req = 1'b1;
        if_addr = 32'h100;
      end
      if (c == 3) begin
        if_cancel = 1'b1;
        if_req = 1'b0;
      end
      if (c == 4) if_cancel = 1'b0;
      @(negedge clk);
      if (if_done) seen = 1'b1;
      if (c == 4) chk("t4_idle_addr", 32'(ram_addr), 0);
      @(posedge clk); #1;
    end
    chk("t4_no_done", 32'(seen), 0);
    op(1'b1, 1'b0, 2'b10, 32'h300, '0, rd);

    // Reset during beat 1 of a store word
    mem_req = 1'b1;
    mem_we = 1'b1;
    mem_len = 2'b10;
    mem_addr = 32'h400;
    mem_wdata = 32'h11223344;
    @(posedge clk); #1;
    @(posedge clk); #1;
    rst = 1'b1;
    mem_req = 1'b0;
    @(negedge clk);
    chk("t5_wr_in_rst", 32'(ram_wr), 0);
    @(posedge clk); #1;
    rst = 1'b0;
    @(negedge clk);
    chk("t5_if_data", if_data, 0);
    chk("t5_mem_rdata", mem_rdata, 0);
    chk("t5_dones", {30'h0, if_done, mem_done}, 0);
    chk("t5_ram_port", {ram_wr, ram_dout, 7'h0, ram_addr}, 0);
    mdl[17'h400] = 8'h44;
    for (int k = 0; k < 4; k++)
      chk("t5_ram_byte", 32'(ram[17'h400 + 17'(k)]), 32'(mdl[17'h400 + 17'(k)]));
    @(posedge clk); #1;

    // Half load wrapping the top of the RAM
    op(1'b0, 1'b0, 2'b01, 32'h1FFFF, '0, rd);
    chk("t6_wrap", rd, {16'h0, mdl[0], mdl[17'h1FFFF]});

    // Random mix against the byte-array model
    for (int i = 0; i < 40; i++) begin
      ra = ($urandom_range(0, 1) == 1 ? 32'h0001_FFF0 : 32'h0000_0600)
           + 32'($urandom_range(0, 15));
      ra[31:17] = 15'($urandom);
      op($urandom_range(0, 3) == 0, 1'($urandom_range(0, 1)),
         2'($urandom_range(0, 3)), ra, $urandom, rd);
    end

    $display("End of test - %0d assertions evaluated, %0d failures",
             n_assert, n_fail);
    $finish;
  end

endmodule
